// File: rtl/pc_flow_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_flow_sequencer_if
//
// Purpose:
//   Data-memory stack port between the PC flow sequencer (master) and the
//   stack memory (slave). One 16-bit half-word moves per completed access.
//
// Signals:
//   memReq   master->slave  stack access request
//   memWrite master->slave  1 = push, 0 = pop
//   memWdata master->slave  push data (16 bits)
//   memAck   slave->master  access complete; memRdata valid in the same cycle
//   memRdata slave->master  pop data (16 bits)
// -----------------------------------------------------------------------------
interface pc_flow_sequencer_if;
    logic        memReq;
    logic        memWrite;
    logic [15:0] memWdata;
    logic        memAck;
    logic [15:0] memRdata;

    modport master (
        output memReq,
        output memWrite,
        output memWdata,
        input  memAck,
        input  memRdata
    );

    modport slave (
        input  memReq,
        input  memWrite,
        input  memWdata,
        output memAck,
        output memRdata
    );
endinterface

// File: rtl/pc_flow_sequencer.sv
// -----------------------------------------------------------------------------
// pc_flow_sequencer
//
// Purpose:
//   Sequences the 32-bit PC through interrupt entry and return-from-interrupt.
//   Interrupt entry: drain the pipeline, push PC[31:16] then PC[15:0] to the
//   stack, then assert startINT (with a one-cycle intAck). Return: pop the low
//   half then the high half, then drive writePcHigh and writePcLow with
//   returnAddress.
//
// Parameters:
//   DRAIN_CYCLES  cycles INTStall is held before the first push (1..15)
//
// Ports:
//   clk            clock, all state updates on posedge
//   Rst            synchronous active-high reset
//   intReq         level interrupt request, held until intAck
//   retReq         one-cycle RET/RTI pulse from decode
//   stallIn        pipeline hazard stall (control hazard OR load-use)
//   pcIn           current PC value
//   mem            stack port (pc_flow_sequencer_if.master)
//   startINT       PC loads the interrupt vector
//   INTStall       freeze PC increment
//   writePcHigh    PC[31:16] <= returnAddress
//   writePcLow     PC[15:0]  <= returnAddress
//   returnAddress  half-word for the PC writes, 0 outside the write states
//   intAck         one-cycle pulse with the first startINT cycle
//   busy           sequencer not idle
//
// Configuration macro:
//   PCSEQ_INT_MASK_EN  when defined, an intEn flag blocks new interrupt entry
//                      from vector dispatch until a return completes.
//
// All outputs are decoded from registered state and saved registers only, so
// they change only at posedge and are stable for the PC register's negedge.
// -----------------------------------------------------------------------------
module pc_flow_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        Rst,
    input  logic                        intReq,
    input  logic                        retReq,
    input  logic                        stallIn,
    input  logic [31:0]                 pcIn,
    pc_flow_sequencer_if.master         mem,
    output logic                        startINT,
    output logic                        INTStall,
    output logic                        writePcHigh,
    output logic                        writePcLow,
    output logic [15:0]                 returnAddress,
    output logic                        intAck,
    output logic                        busy
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_DRAIN   = 4'd1,
        S_PUSH_HI = 4'd2,
        S_PUSH_LO = 4'd3,
        S_VECTOR  = 4'd4,
        S_POP_LO  = 4'd5,
        S_POP_HI  = 4'd6,
        S_WR_HI   = 4'd7,
        S_WR_LO   = 4'd8
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [31:0] savedPc_q;
    logic [15:0] retLo_q;
    logic [15:0] retHi_q;
    logic        firstVec_q;
    logic        intGate;
    logic        enterVector;

`ifdef PCSEQ_INT_MASK_EN
    logic        intEn_q;

    // Blocks nested entry between vector dispatch and the completed return.
    always_ff @(posedge clk) begin
        if (Rst) begin
            intEn_q <= 1'b1;
        end else if (enterVector) begin
            intEn_q <= 1'b0;
        end else if (state_q == S_WR_LO && state_d == S_IDLE) begin
            intEn_q <= 1'b1;
        end
    end

    assign intGate = intEn_q;
`else
    assign intGate = 1'b1;
`endif

    assign enterVector = (state_d == S_VECTOR) && (state_q != S_VECTOR);

    // State register
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; retReq wins over intReq in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (retReq) begin
                    state_d = S_POP_LO;
                end else if (intReq && intGate) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!stallIn && cnt_q == 4'd0) begin
                    state_d = S_PUSH_HI;
                end
            end
            S_PUSH_HI: if (mem.memAck) state_d = S_PUSH_LO;
            S_PUSH_LO: if (mem.memAck) state_d = S_VECTOR;
            S_VECTOR:  if (!stallIn)   state_d = S_IDLE;
            S_POP_LO:  if (mem.memAck) state_d = S_POP_HI;
            S_POP_HI:  if (mem.memAck) state_d = S_WR_HI;
            S_WR_HI:   if (!stallIn)   state_d = S_WR_LO;
            S_WR_LO:   if (!stallIn)   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Drain counter, saved PC and popped halves
    always_ff @(posedge clk) begin
        if (Rst) begin
            cnt_q      <= 4'd0;
            savedPc_q  <= 32'd0;
            retLo_q    <= 16'd0;
            retHi_q    <= 16'd0;
            firstVec_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && state_d == S_DRAIN) begin
                cnt_q     <= DRAIN_LOAD;
                savedPc_q <= pcIn;
            end else if (state_q == S_DRAIN && !stallIn && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_q == S_POP_LO && mem.memAck) begin
                retLo_q <= mem.memRdata;
            end
            if (state_q == S_POP_HI && mem.memAck) begin
                retHi_q <= mem.memRdata;
            end
            // Marks only the first VECTOR cycle so intAck stays a single pulse
            // even when stallIn holds the FSM in VECTOR.
            firstVec_q <= enterVector;
        end
    end

    // Output decode
    always_comb begin
        mem.memReq    = 1'b0;
        mem.memWrite  = 1'b0;
        mem.memWdata  = 16'd0;
        startINT      = 1'b0;
        INTStall      = 1'b0;
        writePcHigh   = 1'b0;
        writePcLow    = 1'b0;
        returnAddress = 16'd0;
        intAck        = 1'b0;
        busy          = (state_q != S_IDLE);
        unique case (state_q)
            S_DRAIN: begin
                INTStall = 1'b1;
            end
            S_PUSH_HI: begin
                mem.memReq   = 1'b1;
                mem.memWrite = 1'b1;
                mem.memWdata = savedPc_q[31:16];
                INTStall     = 1'b1;
            end
            S_PUSH_LO: begin
                mem.memReq   = 1'b1;
                mem.memWrite = 1'b1;
                mem.memWdata = savedPc_q[15:0];
                INTStall     = 1'b1;
            end
            S_VECTOR: begin
                startINT = 1'b1;
                INTStall = 1'b1;
                intAck   = firstVec_q;
            end
            S_POP_LO, S_POP_HI: begin
                mem.memReq = 1'b1;
                INTStall   = 1'b1;
            end
            S_WR_HI: begin
                writePcHigh   = 1'b1;
                returnAddress = retHi_q;
            end
            S_WR_LO: begin
                writePcLow    = 1'b1;
                returnAddress = retLo_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pc_flow_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_flow_sequencer
//
// Directed bench for pc_flow_sequencer (DRAIN_CYCLES = 3). Expected stack
// pushes, vector dispatches and PC half-word writes are queued as each
// scenario is driven and popped as the DUT performs them; cycle-exact output
// values are checked inline.
// -----------------------------------------------------------------------------
module tb_pc_flow_sequencer;

    localparam logic [3:0] K_PUSH = 4'd1;
    localparam logic [3:0] K_VEC  = 4'd2;
    localparam logic [3:0] K_WRHI = 4'd3;
    localparam logic [3:0] K_WRLO = 4'd4;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] data;
    } ev_t;

    logic        clk;
    logic        Rst;
    logic        intReq;
    logic        retReq;
    logic        stallIn;
    logic [31:0] pcIn;
    logic        startINT;
    logic        INTStall;
    logic        writePcHigh;
    logic        writePcLow;
    logic [15:0] returnAddress;
    logic        intAck;
    logic        busy;

    int errors = 0;
    int checks = 0;
    ev_t sb[$];

    pc_flow_sequencer_if memIf ();

    pc_flow_sequencer #(.DRAIN_CYCLES(3)) dut (
        .clk           (clk),
        .Rst           (Rst),
        .intReq        (intReq),
        .retReq        (retReq),
        .stallIn       (stallIn),
        .pcIn          (pcIn),
        .mem           (memIf),
        .startINT      (startINT),
        .INTStall      (INTStall),
        .writePcHigh   (writePcHigh),
        .writePcLow    (writePcLow),
        .returnAddress (returnAddress),
        .intAck        (intAck),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [3:0] kind, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag, input logic [3:0] kind, input logic [15:0] data);
        ev_t e;
        checks++;
        assert (sb.size() > 0)
        else begin
            errors++;
            $error("FAIL %s_unexpected observed=%h expected=none", tag, {kind, data});
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(tag, {12'd0, kind, data}, {12'd0, e.kind, e.data});
        end
    endtask

    // Runs with this cycle's inputs and outputs both settled, before the edge.
    task automatic monitor();
        chk("excl", 32'($countones({startINT, writePcHigh, writePcLow}) <= 1), 32'd1);
        if (!writePcHigh && !writePcLow) chk("retaddr_zero", 32'(returnAddress), 32'd0);
        if (memIf.memReq && memIf.memWrite && memIf.memAck) sb_check("sb_push", K_PUSH, memIf.memWdata);
        if (startINT && intAck) sb_check("sb_vec", K_VEC, 16'd0);
        if (writePcHigh && !stallIn) sb_check("sb_wrhi", K_WRHI, returnAddress);
        if (writePcLow && !stallIn) sb_check("sb_wrlo", K_WRLO, returnAddress);
    endtask

    task automatic tick();
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1;
        intReq = 1'b0;
        retReq = 1'b0;
        stallIn = 1'b0;
        pcIn = 32'd0;
        memIf.memAck = 1'b0;
        memIf.memRdata = 16'd0;
        @(posedge clk);
        #1;
        tick();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_memReq", 32'(memIf.memReq), 32'd0);
        chk("rst_outs", 32'({startINT, INTStall, writePcHigh, writePcLow, intAck, memIf.memWrite}), 32'd0);
        chk("rst_wdata", 32'(memIf.memWdata), 32'd0);
        chk("rst_retaddr", 32'(returnAddress), 32'd0);
        Rst = 1'b0;
        tick();

        // Interrupt entry, zero-wait memory, no stalls
        pcIn = 32'h0001_2345;
        intReq = 1'b1;
        memIf.memAck = 1'b1;
        sb_push(K_PUSH, 16'h0001);
        sb_push(K_PUSH, 16'h2345);
        sb_push(K_VEC, 16'h0000);
        chk("int_c0_stall", 32'(INTStall), 32'd0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            chk("int_drain_stall", 32'(INTStall), 32'd1);
            chk("int_drain_memReq", 32'(memIf.memReq), 32'd0);
            chk("int_drain_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("int_c4_push", 32'({memIf.memReq, memIf.memWrite, memIf.memWdata}), 32'h3_0001);
        chk("int_c4_stall", 32'(INTStall), 32'd1);
        tick();
        chk("int_c5_push", 32'({memIf.memReq, memIf.memWrite, memIf.memWdata}), 32'h3_2345);
        tick();
        chk("int_c6_vec", 32'({startINT, intAck, INTStall, memIf.memReq}), 32'hE);
        intReq = 1'b0;
        tick();
        chk("int_c7_idle", 32'({busy, startINT, INTStall, intAck}), 32'h0);
        chk("int_sb_empty", 32'(sb.size()), 32'd0);

        // Return, zero-wait
        retReq = 1'b1;
        sb_push(K_WRHI, 16'h0001);
        sb_push(K_WRLO, 16'h2345);
        tick();
        retReq = 1'b0;
        memIf.memRdata = 16'h2345;
        chk("ret_c1_pop", 32'({memIf.memReq, memIf.memWrite, INTStall}), 32'h5);
        tick();
        memIf.memRdata = 16'h0001;
        chk("ret_c2_pop", 32'({memIf.memReq, memIf.memWrite, INTStall}), 32'h5);
        tick();
        memIf.memRdata = 16'h0000;
        chk("ret_c3_wrhi", 32'({writePcHigh, writePcLow, returnAddress}), 32'h2_0001);
        chk("ret_c3_memReq", 32'(memIf.memReq), 32'd0);
        tick();
        chk("ret_c4_wrlo", 32'({writePcHigh, writePcLow, returnAddress}), 32'h1_2345);
        tick();
        chk("ret_c5_busy", 32'(busy), 32'd0);
        chk("ret_sb_empty", 32'(sb.size()), 32'd0);

        // Simultaneous intReq and retReq: return first, then entry
        pcIn = 32'hABCD_1234;
        intReq = 1'b1;
        retReq = 1'b1;
        sb_push(K_WRHI, 16'h6666);
        sb_push(K_WRLO, 16'h5555);
        sb_push(K_PUSH, 16'hABCD);
        sb_push(K_PUSH, 16'h1234);
        sb_push(K_VEC, 16'h0000);
        tick();
        retReq = 1'b0;
        memIf.memRdata = 16'h5555;
        chk("both_c1_pop", 32'({memIf.memReq, memIf.memWrite}), 32'h2);
        tick();
        memIf.memRdata = 16'h6666;
        tick();
        chk("both_c3_wrhi", 32'({writePcHigh, returnAddress}), 32'h1_6666);
        tick();
        chk("both_c4_wrlo", 32'({writePcLow, returnAddress}), 32'h1_5555);
        tick();
        chk("both_c5_idle", 32'({busy, INTStall}), 32'h0);
        tick();
        chk("both_c6_drain", 32'({busy, INTStall}), 32'h3);
        tick();
        tick();
        tick();
        chk("both_c9_push", 32'({memIf.memReq, memIf.memWrite, memIf.memWdata}), 32'h3_ABCD);
        tick();
        tick();
        chk("both_c11_vec", 32'({startINT, intAck}), 32'h3);
        intReq = 1'b0;
        tick();
        chk("both_c12_idle", 32'(busy), 32'd0);
        chk("both_sb_empty", 32'(sb.size()), 32'd0);

        // stallIn held 2 cycles during WR_HI
        retReq = 1'b1;
        sb_push(K_WRHI, 16'hF0F0);
        sb_push(K_WRLO, 16'h0F0F);
        tick();
        retReq = 1'b0;
        memIf.memRdata = 16'h0F0F;
        tick();
        memIf.memRdata = 16'hF0F0;
        tick();
        stallIn = 1'b1;
        chk("stl_c3_wrhi", 32'({writePcHigh, writePcLow, returnAddress}), 32'h2_F0F0);
        tick();
        chk("stl_c4_wrhi", 32'({writePcHigh, writePcLow, returnAddress}), 32'h2_F0F0);
        tick();
        stallIn = 1'b0;
        chk("stl_c5_wrhi", 32'({writePcHigh, writePcLow, returnAddress}), 32'h2_F0F0);
        tick();
        chk("stl_c6_wrlo", 32'({writePcHigh, writePcLow, returnAddress}), 32'h1_0F0F);
        tick();
        chk("stl_c7_idle", 32'({busy, writePcLow}), 32'h0);
        chk("stl_sb_empty", 32'(sb.size()), 32'd0);

        // memAck delayed 4 cycles in PUSH_HI, then reset in PUSH_LO
        pcIn = 32'h1357_9BDF;
        intReq = 1'b1;
        memIf.memAck = 1'b0;
        sb_push(K_PUSH, 16'h1357);
        tick();
        intReq = 1'b0;
        tick();
        tick();
        tick();
        for (int c = 4; c <= 7; c++) begin
            chk("wait_push_hi", 32'({memIf.memReq, memIf.memWrite, memIf.memWdata}), 32'h3_1357);
            tick();
        end
        memIf.memAck = 1'b1;
        chk("wait_c8_push_hi", 32'({memIf.memReq, memIf.memWrite, memIf.memWdata}), 32'h3_1357);
        tick();
        memIf.memAck = 1'b0;
        Rst = 1'b1;
        chk("wait_c9_push_lo", 32'({memIf.memReq, memIf.memWrite, memIf.memWdata}), 32'h3_9BDF);
        tick();
        Rst = 1'b0;
        chk("abort_memReq", 32'(memIf.memReq), 32'd0);
        chk("abort_outs", 32'({busy, startINT, INTStall, intAck, writePcHigh, writePcLow}), 32'h0);
        for (int c = 0; c < 6; c++) begin
            chk("abort_no_start", 32'(startINT), 32'd0);
            tick();
        end
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);

`ifdef PCSEQ_INT_MASK_EN
        // Held second request is masked until the return completes
        pcIn = 32'h0000_0042;
        intReq = 1'b1;
        memIf.memAck = 1'b1;
        sb_push(K_PUSH, 16'h0000);
        sb_push(K_PUSH, 16'h0042);
        sb_push(K_VEC, 16'h0000);
        sb_push(K_WRHI, 16'h0000);
        sb_push(K_WRLO, 16'h0042);
        sb_push(K_PUSH, 16'h0000);
        sb_push(K_PUSH, 16'h0077);
        sb_push(K_VEC, 16'h0000);
        repeat (6) tick();
        chk("mask_vec", 32'({startINT, intAck}), 32'h3);
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("mask_blocked", 32'({busy, INTStall}), 32'h0);
            tick();
        end
        retReq = 1'b1;
        tick();
        retReq = 1'b0;
        memIf.memRdata = 16'h0042;
        tick();
        memIf.memRdata = 16'h0000;
        tick();
        pcIn = 32'h0000_0077;
        tick();
        chk("mask_wrlo", 32'({writePcLow, returnAddress}), 32'h1_0042);
        tick();
        chk("mask_idle", 32'(busy), 32'd0);
        tick();
        chk("mask_reentry", 32'({busy, INTStall}), 32'h3);
        repeat (5) tick();
        chk("mask_vec2", 32'({startINT, intAck}), 32'h3);
        intReq = 1'b0;
        tick();
        chk("mask_sb_empty", 32'(sb.size()), 32'd0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
